// File: rtl/lc3_ctrl_pkg.sv
// Shared types for the LC-3 control unit: FSM states, opcodes, mux encodings and the control word.
// Pure declarations, so there is no latency or backpressure here.
package lc3_ctrl_pkg;

    typedef enum logic [4:0] {
        S_HALTED,
        S_F_MAR,
        S_F_READ,
        S_F_IR,
        S_DECODE,
        S_ADD,
        S_AND,
        S_NOT,
        S_BR_CHK,
        S_BR_TAKE,
        S_JMP,
        S_JSR,
        S_JSR_PC,
        S_LDR_ADDR,
        S_LDR_READ,
        S_LDR_WB,
        S_STR_ADDR,
        S_STR_DATA,
        S_STR_WRITE,
        S_PAUSE1,
        S_PAUSE2
    } state_t;

    localparam logic [3:0] OP_BR    = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_JSR   = 4'b0100;
    localparam logic [3:0] OP_AND   = 4'b0101;
    localparam logic [3:0] OP_LDR   = 4'b0110;
    localparam logic [3:0] OP_STR   = 4'b0111;
    localparam logic [3:0] OP_NOT   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1100;
    localparam logic [3:0] OP_PAUSE = 4'b1101;

    localparam logic [1:0] PCMUX_INC   = 2'b00;
    localparam logic [1:0] PCMUX_BUS   = 2'b01;
    localparam logic [1:0] PCMUX_ADDER = 2'b10;

    localparam logic [1:0] ADDR2_ZERO  = 2'b00;
    localparam logic [1:0] ADDR2_OFF6  = 2'b01;
    localparam logic [1:0] ADDR2_OFF9  = 2'b10;
    localparam logic [1:0] ADDR2_OFF11 = 2'b11;

    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_ce;
        logic       mem_oe;
        logic       mem_we;
        logic       halted;
    } ctrl_t;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_F_READ) || (s == S_LDR_READ) || (s == S_STR_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_cnt.sv
// Memory wait-state counter: done pulses on the final cycle of an (MEM_WAIT+1)-cycle access.
// Counts only while en is high and returns to zero whenever en is low or done fires.
module mem_wait_cnt #(
    parameter int MEM_WAIT = 2
) (
    input  logic Clk,
    input  logic Reset,
    input  logic en,
    output logic done
);
    localparam int W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_WAIT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign done = en && (cnt_q == LAST);

    // Clearing on done means the counter never needs to wrap.
    always_comb begin
        cnt_d = '0;
        if (en && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/isdu_control.sv
// LC-3 instruction sequencing/decode FSM; outputs are a Moore decode of the current state.
// Memory states stretch by MEM_WAIT cycles; PAUSE waits for a full Continue press/release.
module isdu_control
    import lc3_ctrl_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        Mem_CE,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic        Halted
);
    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    logic   wait_done;
    logic   unused_ir;

    assign unused_ir = ^{IR[11:6], IR[4:0]};

    mem_wait_cnt #(
        .MEM_WAIT (MEM_WAIT)
    ) u_wait (
        .Clk   (Clk),
        .Reset (Reset),
        .en    (is_mem_state(state_q)),
        .done  (wait_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_HALTED:    if (Run) state_d = S_F_MAR;
            S_F_MAR:     state_d = S_F_READ;
            S_F_READ:    if (wait_done) state_d = S_F_IR;
            S_F_IR:      state_d = S_DECODE;
            S_DECODE: begin
                unique case (IR[15:12])
                    OP_ADD:   state_d = S_ADD;
                    OP_AND:   state_d = S_AND;
                    OP_NOT:   state_d = S_NOT;
                    OP_BR:    state_d = S_BR_CHK;
                    OP_JMP:   state_d = S_JMP;
                    OP_JSR:   state_d = S_JSR;
                    OP_LDR:   state_d = S_LDR_ADDR;
                    OP_STR:   state_d = S_STR_ADDR;
                    OP_PAUSE: state_d = S_PAUSE1;
                    default:  state_d = S_F_MAR;
                endcase
            end
            // BEN was loaded by DECODE one cycle earlier, so it is current here.
            S_BR_CHK:    state_d = BEN ? S_BR_TAKE : S_F_MAR;
            S_JSR:       state_d = S_JSR_PC;
            S_LDR_ADDR:  state_d = S_LDR_READ;
            S_LDR_READ:  if (wait_done) state_d = S_LDR_WB;
            S_STR_ADDR:  state_d = S_STR_DATA;
            S_STR_DATA:  state_d = S_STR_WRITE;
            S_STR_WRITE: if (wait_done) state_d = S_F_MAR;
            S_PAUSE1:    if (Continue) state_d = S_PAUSE2;
            S_PAUSE2:    if (!Continue) state_d = S_F_MAR;
            default:     state_d = S_F_MAR;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= S_HALTED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctrl = '0;
        unique case (state_q)
            S_HALTED: ctrl.halted = 1'b1;
            S_F_MAR: begin
                ctrl.gate_pc = 1'b1;
                ctrl.ld_mar  = 1'b1;
                ctrl.pcmux   = PCMUX_INC;
                ctrl.ld_pc   = 1'b1;
            end
            S_F_READ, S_LDR_READ: begin
                ctrl.mem_ce = 1'b1;
                ctrl.mem_oe = 1'b1;
                ctrl.ld_mdr = 1'b1;
            end
            S_F_IR: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_ir    = 1'b1;
            end
            S_DECODE: ctrl.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl.gate_alu = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
                ctrl.aluk     = (state_q == S_ADD) ? ALUK_ADD :
                                (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
                ctrl.sr2mux   = (state_q != S_NOT) && IR[5];
            end
            S_BR_TAKE: begin
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.addr2mux = ADDR2_OFF9;
                ctrl.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl.sr1mux   = 1'b1;
                ctrl.aluk     = ALUK_PASSA;
                ctrl.gate_alu = 1'b1;
                ctrl.pcmux    = PCMUX_BUS;
                ctrl.ld_pc    = 1'b1;
            end
            S_JSR: begin
                ctrl.drmux   = 1'b1;
                ctrl.gate_pc = 1'b1;
                ctrl.ld_reg  = 1'b1;
            end
            S_JSR_PC: begin
                ctrl.pcmux    = PCMUX_ADDER;
                ctrl.addr2mux = ADDR2_OFF11;
                ctrl.ld_pc    = 1'b1;
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                ctrl.addr1mux    = 1'b1;
                ctrl.addr2mux    = ADDR2_OFF6;
                ctrl.gate_marmux = 1'b1;
                ctrl.ld_mar      = 1'b1;
            end
            S_LDR_WB: begin
                ctrl.gate_mdr = 1'b1;
                ctrl.ld_reg   = 1'b1;
                ctrl.ld_cc    = 1'b1;
            end
            S_STR_DATA: begin
                ctrl.aluk     = ALUK_PASSA;
                ctrl.gate_alu = 1'b1;
                ctrl.ld_mdr   = 1'b1;
            end
            S_STR_WRITE: begin
                ctrl.mem_ce = 1'b1;
                ctrl.mem_we = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign LD_MAR     = ctrl.ld_mar;
    assign LD_MDR     = ctrl.ld_mdr;
    assign LD_IR      = ctrl.ld_ir;
    assign LD_BEN     = ctrl.ld_ben;
    assign LD_CC      = ctrl.ld_cc;
    assign LD_REG     = ctrl.ld_reg;
    assign LD_PC      = ctrl.ld_pc;
    assign GatePC     = ctrl.gate_pc;
    assign GateMDR    = ctrl.gate_mdr;
    assign GateALU    = ctrl.gate_alu;
    assign GateMARMUX = ctrl.gate_marmux;
    assign PCMUX      = ctrl.pcmux;
    assign DRMUX      = ctrl.drmux;
    assign SR1MUX     = ctrl.sr1mux;
    assign SR2MUX     = ctrl.sr2mux;
    assign ADDR1MUX   = ctrl.addr1mux;
    assign ADDR2MUX   = ctrl.addr2mux;
    assign ALUK       = ctrl.aluk;
    assign Mem_CE     = ctrl.mem_ce;
    assign Mem_OE     = ctrl.mem_oe;
    assign Mem_WE     = ctrl.mem_we;
    assign Halted     = ctrl.halted;

endmodule

// File: tb/tb_isdu_control.sv
// Bench for isdu_control: three instances (MEM_WAIT 2, 0, 3) checked cycle by cycle
// against per-instruction expected output sequences built from the instruction semantics.
module tb_isdu_control;

    typedef struct packed {
        logic       ld_mar;
        logic       ld_mdr;
        logic       ld_ir;
        logic       ld_ben;
        logic       ld_cc;
        logic       ld_reg;
        logic       ld_pc;
        logic       gate_pc;
        logic       gate_mdr;
        logic       gate_alu;
        logic       gate_marmux;
        logic [1:0] pcmux;
        logic       drmux;
        logic       sr1mux;
        logic       sr2mux;
        logic       addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic       mem_ce;
        logic       mem_oe;
        logic       mem_we;
        logic       halted;
    } obs_t;

    logic        Clk;
    logic        Reset;
    logic        Run;
    logic        Continue;
    logic [15:0] IR;
    logic        BEN;
    obs_t        obs [3];
    obs_t        exp_q [$];
    int          n_assert;
    int          n_fail;

    function automatic int mw_of(input int g);
        return (g == 0) ? 2 : (g == 1) ? 0 : 3;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic mem_ce, mem_oe, mem_we, halted;
        logic [1:0] pcmux, addr2mux, aluk;

        isdu_control #(.MEM_WAIT(mw_of(g))) u_dut (
            .Clk        (Clk),
            .Reset      (Reset),
            .Run        (Run),
            .Continue   (Continue),
            .IR         (IR),
            .BEN        (BEN),
            .LD_MAR     (ld_mar),
            .LD_MDR     (ld_mdr),
            .LD_IR      (ld_ir),
            .LD_BEN     (ld_ben),
            .LD_CC      (ld_cc),
            .LD_REG     (ld_reg),
            .LD_PC      (ld_pc),
            .GatePC     (gate_pc),
            .GateMDR    (gate_mdr),
            .GateALU    (gate_alu),
            .GateMARMUX (gate_marmux),
            .PCMUX      (pcmux),
            .DRMUX      (drmux),
            .SR1MUX     (sr1mux),
            .SR2MUX     (sr2mux),
            .ADDR1MUX   (addr1mux),
            .ADDR2MUX   (addr2mux),
            .ALUK       (aluk),
            .Mem_CE     (mem_ce),
            .Mem_OE     (mem_oe),
            .Mem_WE     (mem_we),
            .Halted     (halted)
        );

        assign obs[g] = {ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc,
                         gate_pc, gate_mdr, gate_alu, gate_marmux, pcmux,
                         drmux, sr1mux, sr2mux, addr1mux, addr2mux, aluk,
                         mem_ce, mem_oe, mem_we, halted};
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input int g, input obs_t e, input string tag);
        obs_t o;
        o = obs[g];
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, g, o, e);
        end
    endtask

    // Expected per-cycle outputs for one instruction, from fetch to the cycle before the next fetch.
    task automatic build(input logic [15:0] ir, input logic ben, input int mw);
        obs_t e;
        exp_q.delete();
        e = '0; e.gate_pc = 1; e.ld_mar = 1; e.ld_pc = 1;           exp_q.push_back(e);
        e = '0; e.mem_ce = 1; e.mem_oe = 1; e.ld_mdr = 1;
        repeat (mw + 1) exp_q.push_back(e);
        e = '0; e.gate_mdr = 1; e.ld_ir = 1;                        exp_q.push_back(e);
        e = '0; e.ld_ben = 1;                                       exp_q.push_back(e);
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                e = '0; e.gate_alu = 1; e.ld_reg = 1; e.ld_cc = 1;
                e.aluk   = (ir[15:12] == 4'h1) ? 2'd0 : (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
                e.sr2mux = (ir[15:12] != 4'h9) && ir[5];
                exp_q.push_back(e);
            end
            4'h0: begin
                e = '0; exp_q.push_back(e);
                if (ben) begin
                    e.pcmux = 2'b10; e.addr2mux = 2'b10; e.ld_pc = 1; exp_q.push_back(e);
                end
            end
            4'hC: begin
                e = '0; e.sr1mux = 1; e.aluk = 2'b11; e.gate_alu = 1; e.pcmux = 2'b01; e.ld_pc = 1;
                exp_q.push_back(e);
            end
            4'h4: begin
                e = '0; e.drmux = 1; e.gate_pc = 1; e.ld_reg = 1;      exp_q.push_back(e);
                e = '0; e.pcmux = 2'b10; e.addr2mux = 2'b11; e.ld_pc = 1; exp_q.push_back(e);
            end
            4'h6, 4'h7: begin
                e = '0; e.addr1mux = 1; e.addr2mux = 2'b01; e.gate_marmux = 1; e.ld_mar = 1;
                exp_q.push_back(e);
                if (ir[15:12] == 4'h6) begin
                    e = '0; e.mem_ce = 1; e.mem_oe = 1; e.ld_mdr = 1;
                    repeat (mw + 1) exp_q.push_back(e);
                    e = '0; e.gate_mdr = 1; e.ld_reg = 1; e.ld_cc = 1; exp_q.push_back(e);
                end else begin
                    e = '0; e.aluk = 2'b11; e.gate_alu = 1; e.ld_mdr = 1; exp_q.push_back(e);
                    e = '0; e.mem_ce = 1; e.mem_we = 1;
                    repeat (mw + 1) exp_q.push_back(e);
                end
            end
            default: ;
        endcase
    endtask

    // Caller leaves the DUT one cycle before F_MAR; returns with the DUT one cycle before the next F_MAR.
    task automatic run_instr(input int g, input logic [15:0] ir, input logic ben, input int hold);
        obs_t z;
        z = '0;
        build(ir, ben, mw_of(g));
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge Clk);
            chk(g, exp_q[i], $sformatf("ir%h_cyc%0d", ir, i));
            if (i == 0) begin
                IR = ir; BEN = ben; Continue = 1'b0;
            end
        end
        if (ir[15:12] == 4'hD) begin
            repeat ($urandom_range(1, 3)) begin
                @(negedge Clk);
                chk(g, z, "pause1_hold");
            end
            Continue = 1'b1;
            repeat (hold) begin
                @(negedge Clk);
                chk(g, z, "pause2_hold");
            end
            Continue = 1'b0;
        end
    endtask

    task automatic restart();
        @(negedge Clk);
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b1;
    endtask

    task automatic random_instrs(input int g, input int n);
        logic [3:0]  ops [11];
        logic [15:0] ir;
        ops = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'h4, 4'h6, 4'h7, 4'hD, 4'h2, 4'hF};
        for (int k = 0; k < n; k++) begin
            ir = 16'($urandom);
            ir[15:12] = ops[$urandom_range(0, 10)];
            run_instr(g, ir, 1'($urandom), $urandom_range(1, 4));
        end
    endtask

    initial begin
        obs_t h;
        h = '0; h.halted = 1'b1;
        n_assert = 0; n_fail = 0;
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0; IR = 16'h0000; BEN = 1'b0;

        repeat (2) @(negedge Clk);
        for (int g = 0; g < 3; g++) chk(g, h, "reset_state");
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk(0, h, "halted_no_run");
        end

        // Async reset mid-fetch must drop every output within the cycle.
        Run = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        chk(0, exp_q.size() == 0 ? obs[0] : obs[0], "fetch_read_pre");
        @(posedge Clk);
        #2 Reset = 1'b1; Run = 1'b0;
        #1 chk(0, h, "reset_mid_read");
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            chk(0, h, "halted_after_reset");
        end
        Run = 1'b1;

        run_instr(0, 16'h1042, 1'b0, 1);
        run_instr(0, 16'h5062, 1'b0, 1);
        run_instr(0, 16'h0E05, 1'b1, 1);
        run_instr(0, 16'h0E05, 1'b0, 1);
        run_instr(0, 16'hC1C0, 1'b0, 1);
        run_instr(0, 16'h4805, 1'b0, 1);
        run_instr(0, 16'h6283, 1'b0, 1);
        run_instr(0, 16'h7283, 1'b0, 1);
        run_instr(0, 16'h903F, 1'b0, 1);
        run_instr(0, 16'hD000, 1'b0, 10);
        run_instr(0, 16'hF025, 1'b0, 1);
        run_instr(0, 16'h1062, 1'b0, 1);
        random_instrs(0, 60);

        restart();
        run_instr(1, 16'h6283, 1'b0, 1);
        run_instr(1, 16'h7283, 1'b0, 1);
        random_instrs(1, 30);

        // Run and Continue together in HALTED: Run wins.
        @(negedge Clk);
        Reset = 1'b1; Run = 1'b0; Continue = 1'b0;
        @(negedge Clk);
        Reset = 1'b0; Run = 1'b1; Continue = 1'b1;
        run_instr(2, 16'h7283, 1'b0, 1);
        random_instrs(2, 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
